// File: rtl/hilo_pkg.sv
// Shared op codes, FSM encoding and default sizing for the HI/LO divide controller.
package hilo_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 40;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MTHI = 3'd1;
  localparam logic [2:0] OP_MTLO = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE
  } state_e;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair with independent write enables.
module hilo_regs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, lo_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_div_ctrl.sv
// Execute-stage controller: launches the iterative divider, commits remainder/quotient to
// HI/LO, serves MTHI/MTLO/MFHI/MFLO and stalls the pipeline while a divide is in flight.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic             lat_we, accept;
  logic             hi_we, lo_we;
  logic [WIDTH-1:0] hi_wdata, lo_wdata;

  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clock    (clock),
    .reset    (reset),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi       (hi),
    .lo       (lo)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (lat_we) begin
        dividend_q <= op_a;
        divisor_q  <= op_b;
      end
    end
  end

  always_comb begin
    stall     = op_valid && (state_q != IDLE);
    accept    = op_valid && !stall;
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    lat_we    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_wdata  = op_a;
    lo_wdata  = op_a;
    div_start = 1'b0;
    rd_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            OP_MFHI: rd_data = hi;
            OP_MFLO: rd_data = lo;
            OP_DIV: begin
              // Divide by zero is silently dropped: no launch, no error.
              if (op_b != '0) begin
                lat_we  = 1'b1;
                cnt_d   = '0;
                state_d = ISSUE;
              end
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        if (div_busy) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT: begin
        if (!div_busy) begin
          state_d = WRITE;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WRITE: begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_wdata = div_r;
        lo_wdata = div_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err          = err_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a negedge-updating 32-cycle divider model.
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             op_valid = 1'b0;
  logic [2:0]       op = OP_NONE;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic             stall, err, div_start;
  logic [WIDTH-1:0] rd_data, hi, lo, div_dividend, div_divisor;
  logic             div_busy;
  logic [WIDTH-1:0] div_q, div_r;

  int n_run = 0, n_fail = 0;
  int err_cnt = 0, start_cnt = 0, m_cnt;
  logic div_hang = 1'b0;

  hilo_div_ctrl #(
    .WIDTH   (WIDTH),
    .TIMEOUT (40)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op           (op),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .rd_data      (rd_data),
    .hi           (hi),
    .lo           (lo),
    .err          (err),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  always #5 clock = ~clock;

  // Divider model: answers 32 negedges after seeing start.
  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      div_busy <= 1'b0;
      m_cnt    <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (!div_hang) begin
      if (div_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) div_busy <= 1'b0;
      end else if (div_start) begin
        div_busy <= 1'b1;
        m_cnt    <= 32;
        div_q    <= $signed(div_dividend) / $signed(div_divisor);
        div_r    <= $signed(div_dividend) % $signed(div_divisor);
      end
    end
  end

  always @(posedge clock) begin
    if (err) err_cnt <= err_cnt + 1;
    if (div_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = v;
    op       = o;
    op_a     = a;
    op_b     = b;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds the current op and counts cycles until stall drops (bounded).
  task automatic wait_unstall(output int n);
    n = 0;
    while (stall && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n, e0, s0;

  initial begin
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dividend", div_dividend, 32'h0);
    chk("rst_divisor", div_divisor, 32'h0);
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: 100 / 7 with a held MFLO behind it
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    chk("t1_accept_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    chk("t1_busy_stall", {31'd0, stall}, 32'd1);
    chk("t1_dividend", div_dividend, 32'd100);
    chk("t1_divisor", div_divisor, 32'd7);
    wait_unstall(n);
    chk("t1_latency_window", {31'd0, (n >= 34 && n <= 38)}, 32'd1);
    chk("t1_mflo", rd_data, 32'd14);
    chk("t1_lo", lo, 32'd14);
    chk("t1_hi", hi, 32'd2);

    // 2: -100 / 7
    drive(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7);
    tick();
    drive(1'b1, OP_NONE, 32'h0, 32'h0);
    wait_unstall(n);
    chk("t2_done", {31'd0, stall}, 32'd0);
    chk("t2_lo", lo, 32'hFFFF_FFF2);
    chk("t2_hi", hi, 32'hFFFF_FFFE);
    chk("t2_no_err", err_cnt, 32'd0);

    // 3: back-to-back moves
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("t3_mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t3_hi", hi, 32'hDEAD_BEEF);
    drive(1'b1, OP_MTLO, 32'h1234_5678, 32'h0);
    chk("t3_mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t3_lo", lo, 32'h1234_5678);
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    chk("t3_mfhi", rd_data, 32'hDEAD_BEEF);
    chk("t3_mfhi_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    chk("t3_mflo", rd_data, 32'h1234_5678);
    chk("t3_mflo_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b0, OP_MFLO, 32'h0, 32'h0);
    chk("t3_rd_idle", rd_data, 32'h0);

    // 4: divide by zero is ignored
    drive(1'b1, OP_MTHI, 32'd5, 32'h0);
    tick();
    drive(1'b1, OP_MTLO, 32'd6, 32'h0);
    tick();
    s0 = start_cnt;
    drive(1'b1, OP_DIV, 32'd77, 32'd0);
    tick();
    drive(1'b1, OP_NONE, 32'h0, 32'h0);
    chk("t4_stall", {31'd0, stall}, 32'd0);
    tick();
    tick();
    chk("t4_start", start_cnt, s0);
    chk("t4_hi", hi, 32'd5);
    chk("t4_lo", lo, 32'd6);
    chk("t4_dividend_held", div_dividend, 32'hFFFF_FF9C);
    chk("t4_err", err_cnt, 32'd0);

    // 5: divider never goes busy -> timeout
    div_hang = 1'b1;
    e0 = err_cnt;
    drive(1'b1, OP_DIV, 32'd50, 32'd5);
    tick();
    drive(1'b0, OP_NONE, 32'h0, 32'h0);
    n = 0;
    while (!err && n < 60) begin
      tick();
      n++;
    end
    chk("t5_err_delay", n, 32'd40);
    tick();
    chk("t5_err_pulse", {31'd0, err}, 32'd0);
    tick();
    chk("t5_err_count", err_cnt - e0, 32'd1);
    chk("t5_hi", hi, 32'd5);
    chk("t5_lo", lo, 32'd6);
    div_hang = 1'b0;
    drive(1'b1, OP_DIV, 32'd9, 32'd2);
    chk("t5_next_accept", {31'd0, stall}, 32'd0);
    tick();
    chk("t5_next_start", {31'd0, div_start}, 32'd1);
    drive(1'b1, OP_NONE, 32'h0, 32'h0);
    wait_unstall(n);
    chk("t5_next_window", {31'd0, (n >= 34 && n <= 38)}, 32'd1);
    chk("t5_next_lo", lo, 32'd4);
    chk("t5_next_hi", hi, 32'd1);

    // 6: reset in the middle of WAIT
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    tick();
    drive(1'b1, OP_NONE, 32'h0, 32'h0);
    repeat (10) tick();
    chk("t6_pre_stall", {31'd0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_stall", {31'd0, stall}, 32'd0);
    chk("t6_async_start", {31'd0, div_start}, 32'd0);
    chk("t6_async_hi", hi, 32'h0);
    chk("t6_async_lo", lo, 32'h0);
    chk("t6_async_dividend", div_dividend, 32'h0);
    #3;
    reset = 1'b1;
    tick();
    drive(1'b1, OP_MFHI, 32'h0, 32'h0);
    chk("t6_post_stall", {31'd0, stall}, 32'd0);
    chk("t6_post_rd", rd_data, 32'h0);
    tick();
    tick();
    chk("t6_post_start", {31'd0, div_start}, 32'd0);
    chk("t6_post_lo", lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
